regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the 64-bit, 32-entry register file (X31 = XZR). Two independent write-back requesters (ALU path, load path) each feed a small per-requester FIFO. A round-robin arbiter drains the FIFOs one entry per cycle into a registered write stage that drives the register file's single write port (RegWr/RW/BusW). A scoreboard query port tells the hazard logic whether a register still has a write in flight.

## Interface
Parameters:
- DEPTH, 2: entries per requester FIFO; power of two, ≥2.
- DW, 64: data width.

Ports (one clock; reset is asynchronous and active-low):
- Clk  input  1  clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Valid0  input  1  requester 0 has a write.
- Addr0  input  5  requester 0 destination register.
- Data0  input  DW  requester 0 write data.
- Ready0  output  1  requester 0 FIFO can accept.
- Valid1 / Addr1 / Data1 / Ready1: same roles for requester 1.
- RegWr  output  1  register-file write enable (registered).
- RW  output  5  register-file write address (registered).
- BusW  output  DW  register-file write data (registered).
- QA  input  5  scoreboard query address.
- QBusy  output  1  a queued or in-flight write targets QA.
- Idle  output  1  both FIFOs empty and RegWr=0.

## Operation
- Handshake per requester: transfer when Valid&&Ready at the rising edge. ReadyN = Reset_n && (countN < DEPTH). A full FIFO deasserts Ready even in a cycle where it is also being popped.
- Valid/Addr/Data must stay stable while Valid=1 and Ready=0. The bench checks this; the RTL does not.
- Addr=31 (XZR) transfers complete normally but are discarded. No FIFO entry is created, countN is unchanged, and no RegWr pulse ever results.
- Each FIFO is in-order, with a DEPTH-entry circular buffer and wrapping read/write pointers. A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Arbitration, evaluated every cycle from the FIFO state before the edge:
  - Neither FIFO non-empty: no grant.
  - Exactly one non-empty: grant it.
  - Both non-empty: grant the requester that is not LastGrant.
  - On a grant, LastGrant takes the granted index. With no grant, LastGrant holds.
- Write stage, on each edge:
  - Grant: pop the head of the granted FIFO; RegWr<=1, RW<=head addr, BusW<=head data.
  - No grant: RegWr<=0; RW and BusW hold their last values.
- QBusy is combinational. It is 1 iff QA≠31 and at least one of these holds:
  - any occupied entry in FIFO0 or FIFO1 has addr==QA;
  - RegWr=1 and RW==QA.
- Idle is combinational: count0==0 && count1==0 && RegWr==0.
- Same-address writes from different requesters are ordered by grant order only; no cross-requester ordering is guaranteed.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - Both FIFOs flushed, counts=0, pointers=0.
  - LastGrant=1, so requester 0 wins the first contended cycle.
  - RegWr=0, RW=0, BusW=0.
  - Ready0=Ready1=0 while Reset_n=0; both go to 1 on the deassertion, without waiting for an edge.
  - QBusy=0, Idle=1.
- Latency: accept at edge N into an empty, uncontended FIFO → RegWr=1 after edge N+1 → register file stores the value at edge N+2. The value is readable on BusA/BusB after edge N+2.
- Throughput: one register-file write per cycle in aggregate. Under contention each requester gets every other cycle.
- RegWr is a single-cycle pulse per entry. Back-to-back grants hold RegWr=1 continuously.
- QBusy for an entry goes to 1 in the cycle after its accept edge and to 0 after the edge at which the register file stores it (RegWr dropped or RW changed).
- Entries accepted in a cycle cannot be granted in that same cycle; there is no FIFO bypass.

## Test plan
- Reset defaults: hold Reset_n=0 mid-stream with FIFOs holding 2+1 entries → immediately RegWr=0, RW=0, BusW=0, Ready0/1=0, Idle=1. After release, Ready0/1=1, and no stale write ever appears.
- Single write latency: Valid0, Addr0=5, Data0=64'hDEAD_BEEF accepted at edge N → RegWr=1, RW=5, BusW=DEAD_BEEF during cycle N+1..N+2 only. Register-file BusA with RA=5 reads DEAD_BEEF after edge N+2. QBusy with QA=5 is 1 between those edges.
- Round-robin: fill both FIFOs (req0: r1,r2; req1: r3,r4) in the same cycles → RW sequence 1,3,2,4 on four consecutive RegWr=1 cycles, then Idle=1.
- Full/backpressure with DEPTH=2: hold Valid1=1 with three distinct entries while requester 0 stays busy → Ready1=0 after two accepts. The third entry is accepted only after a pop, no entry is lost or duplicated, and per-requester order is preserved.
- XZR drop: Valid0, Addr0=31, Data0=1 → accepted with Ready0=1, count unchanged, RegWr never asserts. QBusy with QA=31 stays 0, and Idle stays 1.
- Scoreboard: queue writes to r7 from both requesters → QBusy(QA=7)=1 until the second write to r7 retires, then 0. QBusy(QA=8)=0 throughout.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32-entry register file (X31 = XZR).
// Two requesters (ALU, load) each push into a small in-order FIFO. A
// round-robin arbiter drains one entry per cycle into a registered write
// stage that drives RegWr/RW/BusW. QBusy reports whether a queued or
// in-flight write targets register QA.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 64
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Valid0,
  input  logic [4:0]    Addr0,
  input  logic [DW-1:0] Data0,
  output logic          Ready0,
  input  logic          Valid1,
  input  logic [4:0]    Addr1,
  input  logic [DW-1:0] Data1,
  output logic          Ready1,
  output logic          RegWr,
  output logic [4:0]    RW,
  output logic [DW-1:0] BusW,
  input  logic [4:0]    QA,
  output logic          QBusy,
  output logic          Idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] XZR = 5'd31;

  // Per-requester views of the ports so both FIFOs share one description
  logic [1:0]    in_valid;
  logic [4:0]    in_addr [2];
  logic [DW-1:0] in_data [2];
  logic [1:0]    ready;
  logic [1:0]    push;
  logic [1:0]    pop;

  // FIFO storage and bookkeeping
  logic [4:0]    addr_mem_q [2][DEPTH];
  logic [4:0]    addr_mem_d [2][DEPTH];
  logic [DW-1:0] data_mem_q [2][DEPTH];
  logic [DW-1:0] data_mem_d [2][DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] count_q [2];
  logic [CW-1:0] count_d [2];

  // Arbiter and write stage
  logic          last_grant_q, last_grant_d;
  logic          grant_valid;
  logic          grant_idx;
  logic          regwr_q, regwr_d;
  logic [4:0]    rw_q, rw_d;
  logic [DW-1:0] busw_q, busw_d;

  logic          qbusy_hit;
  logic [PW-1:0] occ_off;

  assign in_valid   = {Valid1, Valid0};
  assign in_addr[0] = Addr0;
  assign in_addr[1] = Addr1;
  assign in_data[0] = Data0;
  assign in_data[1] = Data1;

  // Ready is forced low during reset and returns as soon as reset releases
  assign ready[0] = Reset_n && (count_q[0] < CW'(DEPTH));
  assign ready[1] = Reset_n && (count_q[1] < CW'(DEPTH));
  assign Ready0   = ready[0];
  assign Ready1   = ready[1];

  // XZR writes handshake normally but never create an entry
  assign push[0] = in_valid[0] && ready[0] && (in_addr[0] != XZR);
  assign push[1] = in_valid[1] && ready[1] && (in_addr[1] != XZR);

  // Round-robin grant from pre-edge FIFO occupancy; a tie goes to the
  // requester that did not win last time
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if ((count_q[0] != '0) && (count_q[1] != '0)) begin
      grant_valid = 1'b1;
      grant_idx   = ~last_grant_q;
    end else if (count_q[0] != '0) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b0;
    end else if (count_q[1] != '0) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b1;
    end
  end

  assign pop[0] = grant_valid && !grant_idx;
  assign pop[1] = grant_valid && grant_idx;

  // Next-state for both FIFOs, the grant history and the write stage
  always_comb begin
    addr_mem_d   = addr_mem_q;
    data_mem_d   = data_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    regwr_d      = grant_valid;
    rw_d         = rw_q;
    busw_d       = busw_q;
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        addr_mem_d[r][wr_ptr_q[r]] = in_addr[r];
        data_mem_d[r][wr_ptr_q[r]] = in_data[r];
        wr_ptr_d[r]                = wr_ptr_q[r] + PW'(1);
      end
      if (pop[r]) begin
        rd_ptr_d[r] = rd_ptr_q[r] + PW'(1);
      end
      case ({push[r], pop[r]})
        2'b10:   count_d[r] = count_q[r] + CW'(1);
        2'b01:   count_d[r] = count_q[r] - CW'(1);
        default: count_d[r] = count_q[r];
      endcase
    end
    if (grant_valid) begin
      last_grant_d = grant_idx;
      rw_d         = addr_mem_q[grant_idx][rd_ptr_q[grant_idx]];
      busw_d       = data_mem_q[grant_idx][rd_ptr_q[grant_idx]];
    end
  end

  // State registers; reset flushes both FIFOs and biases the first tie to requester 0
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < DEPTH; i++) begin
          addr_mem_q[r][i] <= '0;
          data_mem_q[r][i] <= '0;
        end
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        count_q[r]  <= '0;
      end
      last_grant_q <= 1'b1;
      regwr_q      <= 1'b0;
      rw_q         <= '0;
      busw_q       <= '0;
    end else begin
      addr_mem_q   <= addr_mem_d;
      data_mem_q   <= data_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      regwr_q      <= regwr_d;
      rw_q         <= rw_d;
      busw_q       <= busw_d;
    end
  end

  // Hazard query: any occupied FIFO slot or the in-flight write matching QA
  always_comb begin
    qbusy_hit = 1'b0;
    occ_off   = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        occ_off = PW'(i) - rd_ptr_q[r];
        if (({1'b0, occ_off} < count_q[r]) && (addr_mem_q[r][i] == QA)) begin
          qbusy_hit = 1'b1;
        end
      end
    end
    if (regwr_q && (rw_q == QA)) begin
      qbusy_hit = 1'b1;
    end
    if (QA == XZR) begin
      qbusy_hit = 1'b0;
    end
  end

  assign QBusy = qbusy_hit;
  assign Idle  = (count_q[0] == '0) && (count_q[1] == '0) && !regwr_q;
  assign RegWr = regwr_q;
  assign RW    = rw_q;
  assign BusW  = busw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: accepted writes are pushed to
// per-requester expected queues and matched against every RegWr pulse,
// plus table-driven single-write latency vectors and hand-written
// sequences for reset, round-robin, backpressure, XZR and the scoreboard.
module tb_regfile_wb_arbiter;

  localparam int DW = 64;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Valid0, Valid1;
  logic [4:0]    Addr0, Addr1;
  logic [DW-1:0] Data0, Data1;
  logic          Ready0, Ready1;
  logic          RegWr;
  logic [4:0]    RW;
  logic [DW-1:0] BusW;
  logic [4:0]    QA;
  logic          QBusy;
  logic          Idle;

  int total = 0;
  int bad   = 0;

  typedef logic [68:0] wb_t;
  wb_t q0[$];
  wb_t q1[$];
  logic acc0, acc1;

  typedef struct {
    logic          req;
    logic [4:0]    addr;
    logic [DW-1:0] data;
    logic          exp_write;
  } vec_t;
  vec_t vecs[6];

  regfile_wb_arbiter #(.DEPTH(2), .DW(DW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Valid0(Valid0), .Addr0(Addr0), .Data0(Data0), .Ready0(Ready0),
    .Valid1(Valid1), .Addr1(Addr1), .Data1(Data1), .Ready1(Ready1),
    .RegWr(RegWr), .RW(RW), .BusW(BusW),
    .QA(QA), .QBusy(QBusy), .Idle(Idle)
  );

  always #5 Clk = ~Clk;

  // Hard stop if something stalls the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [63:0] d1);
    Valid0 = v0; Addr0 = a0; Data0 = d0;
    Valid1 = v1; Addr1 = a1; Data1 = d1;
  endtask

  task automatic idleStimulus();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // One clock: record handshakes seen before the edge, then match any write
  task automatic tick();
    wb_t got;
    acc0 = Valid0 && Ready0;
    acc1 = Valid1 && Ready1;
    if (acc0 && Addr0 != 5'd31) q0.push_back({Addr0, Data0});
    if (acc1 && Addr1 != 5'd31) q1.push_back({Addr1, Data1});
    @(posedge Clk);
    #1;
    if (RegWr) begin
      got = {RW, BusW};
      total++;
      if (q0.size() > 0 && q0[0] === got) void'(q0.pop_front());
      else if (q1.size() > 0 && q1[0] === got) void'(q1.pop_front());
      else begin
        bad++;
        $display("[TB] FAIL wb_order: got RW=%0d BusW=%h expected head of a requester queue", RW, BusW);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!Idle && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_idle", Idle, 64'd1);
    checkOutput("sb_q0_empty", q0.size(), 64'd0);
    checkOutput("sb_q1_empty", q1.size(), 64'd0);
  endtask

  function automatic logic [63:0] rrData(input int a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  initial begin
    int rr_exp[4];
    int sb_exp[4];
    int i0, i1, first_full;

    vecs[0] = '{req: 1'b0, addr: 5'd5,  data: 64'h0000_0000_DEAD_BEEF, exp_write: 1'b1};
    vecs[1] = '{req: 1'b1, addr: 5'd0,  data: 64'h0123_4567_89AB_CDEF, exp_write: 1'b1};
    vecs[2] = '{req: 1'b0, addr: 5'd30, data: 64'h8000_0000_0000_0001, exp_write: 1'b1};
    vecs[3] = '{req: 1'b1, addr: 5'd31, data: 64'h5555_5555_5555_5555, exp_write: 1'b0};
    vecs[4] = '{req: 1'b0, addr: 5'd31, data: 64'h0000_0000_0000_0001, exp_write: 1'b0};
    vecs[5] = '{req: 1'b1, addr: 5'd17, data: 64'hFFFF_FFFF_FFFF_FFFF, exp_write: 1'b1};
    rr_exp = '{1, 3, 2, 4};
    sb_exp = '{1, 1, 1, 0};

    // ---------------- power-on reset ----------------
    Reset_n = 1'b0;
    QA = 5'd0;
    idleStimulus();
    repeat (2) tick();
    checkOutput("rst_regwr", RegWr, 64'd0);
    checkOutput("rst_rw", RW, 64'd0);
    checkOutput("rst_busw", BusW, 64'd0);
    checkOutput("rst_ready0", Ready0, 64'd0);
    checkOutput("rst_ready1", Ready1, 64'd0);
    checkOutput("rst_idle", Idle, 64'd1);
    checkOutput("rst_qbusy", QBusy, 64'd0);
    #2 Reset_n = 1'b1;
    #1;
    checkOutput("rel_ready0", Ready0, 64'd1);
    checkOutput("rel_ready1", Ready1, 64'd1);

    // ---------------- reset in mid-stream ----------------
    applyStimulus(1'b1, 5'd1, 64'hBAD0_0000_0000_0001, 1'b1, 5'd3, 64'hBAD0_0000_0000_0003);
    tick();
    applyStimulus(1'b1, 5'd2, 64'hBAD0_0000_0000_0002, 1'b1, 5'd4, 64'hBAD0_0000_0000_0004);
    tick();
    idleStimulus();
    checkOutput("mid_regwr", RegWr, 64'd1);
    Reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_regwr", RegWr, 64'd0);
    checkOutput("mid_rst_rw", RW, 64'd0);
    checkOutput("mid_rst_busw", BusW, 64'd0);
    checkOutput("mid_rst_ready0", Ready0, 64'd0);
    checkOutput("mid_rst_ready1", Ready1, 64'd0);
    checkOutput("mid_rst_idle", Idle, 64'd1);
    q0.delete();
    q1.delete();
    repeat (2) tick();
    #2 Reset_n = 1'b1;
    #1;
    checkOutput("mid_rel_ready0", Ready0, 64'd1);
    checkOutput("mid_rel_ready1", Ready1, 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("no_stale_regwr", RegWr, 64'd0);
    end

    // ---------------- round-robin after reset ----------------
    applyStimulus(1'b1, 5'd1, rrData(1), 1'b1, 5'd3, rrData(3));
    tick();
    checkOutput("rr_first_regwr", RegWr, 64'd0);
    applyStimulus(1'b1, 5'd2, rrData(2), 1'b1, 5'd4, rrData(4));
    tick();
    idleStimulus();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rr%0d_regwr", k), RegWr, 64'd1);
      checkOutput($sformatf("rr%0d_rw", k), RW, 64'(rr_exp[k]));
      checkOutput($sformatf("rr%0d_busw", k), BusW, rrData(rr_exp[k]));
      tick();
    end
    checkOutput("rr_end_regwr", RegWr, 64'd0);
    checkOutput("rr_end_idle", Idle, 64'd1);

    // ---------------- single-write latency table ----------------
    for (int v = 0; v < 6; v++) begin
      QA = vecs[v].addr;
      applyStimulus(!vecs[v].req, vecs[v].addr, vecs[v].data,
                    vecs[v].req, vecs[v].addr, vecs[v].data);
      #1;
      checkOutput($sformatf("vec%0d_ready", v), vecs[v].req ? Ready1 : Ready0, 64'd1);
      tick();
      idleStimulus();
      checkOutput($sformatf("vec%0d_acc_regwr", v), RegWr, 64'd0);
      checkOutput($sformatf("vec%0d_acc_qbusy", v), QBusy, 64'(vecs[v].exp_write));
      checkOutput($sformatf("vec%0d_acc_idle", v), Idle, 64'(!vecs[v].exp_write));
      tick();
      checkOutput($sformatf("vec%0d_wr_regwr", v), RegWr, 64'(vecs[v].exp_write));
      checkOutput($sformatf("vec%0d_wr_qbusy", v), QBusy, 64'(vecs[v].exp_write));
      if (vecs[v].exp_write) begin
        checkOutput($sformatf("vec%0d_wr_rw", v), RW, 64'(vecs[v].addr));
        checkOutput($sformatf("vec%0d_wr_busw", v), BusW, vecs[v].data);
      end
      tick();
      checkOutput($sformatf("vec%0d_done_regwr", v), RegWr, 64'd0);
      checkOutput($sformatf("vec%0d_done_qbusy", v), QBusy, 64'd0);
      checkOutput($sformatf("vec%0d_done_idle", v), Idle, 64'd1);
      if (vecs[v].exp_write)
        checkOutput($sformatf("vec%0d_rw_hold", v), RW, 64'(vecs[v].addr));
    end

    // ---------------- backpressure on requester 1 ----------------
    QA = 5'd8;
    i0 = 0;
    i1 = 0;
    first_full = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (i0 == 4 && i1 == 3) break;
      applyStimulus(i0 < 4, 5'(10 + i0), 64'hA000_0000_0000_0000 | 64'(i0),
                    i1 < 3, 5'(20 + i1), 64'hB000_0000_0000_0000 | 64'(i1));
      #1;
      if (Valid1 && !Ready1 && first_full < 0) first_full = i1;
      tick();
      if (acc0) i0++;
      if (acc1) i1++;
    end
    idleStimulus();
    checkOutput("bp_full_after_two", 64'(first_full), 64'd2);
    checkOutput("bp_all_req0", 64'(i0), 64'd4);
    checkOutput("bp_all_req1", 64'(i1), 64'd3);
    drain(20);

    // ---------------- XZR drop ----------------
    QA = 5'd31;
    applyStimulus(1'b1, 5'd31, 64'd1, 1'b0, 5'd0, 64'd0);
    #1;
    checkOutput("xzr_ready0", Ready0, 64'd1);
    tick();
    idleStimulus();
    checkOutput("xzr_regwr", RegWr, 64'd0);
    checkOutput("xzr_qbusy", QBusy, 64'd0);
    checkOutput("xzr_idle", Idle, 64'd1);
    tick();
    checkOutput("xzr_regwr2", RegWr, 64'd0);
    checkOutput("xzr_idle2", Idle, 64'd1);

    // ---------------- scoreboard on r7 from both requesters ----------------
    QA = 5'd7;
    applyStimulus(1'b1, 5'd7, 64'h7000_0000_0000_0000, 1'b1, 5'd7, 64'h7100_0000_0000_0000);
    tick();
    idleStimulus();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("sb%0d_qbusy7", k), QBusy, 64'(sb_exp[k]));
      QA = 5'd8;
      #1;
      checkOutput($sformatf("sb%0d_qbusy8", k), QBusy, 64'd0);
      QA = 5'd7;
      #1;
      if (k < 3) tick();
    end
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
